tv_window_capture: RTL and testbench

//  Parametrised successor to the fixed 720x240/288 field gate. Takes decoded TV pixels and

---
 rtl/tv_window_capture.sv | 231 +++++++++++++++++++++++
 tb/tb_tv_window_capture.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tv_window_capture.sv
// tv_window_capture
// Cuts a run-time window out of a decoded TV pixel stream and hands it to the
// frame-buffer writer as a qualified pixel stream with a linear address.
// Supports single-field capture (field 0 or 1), two-field weave, and optional
// 2:1 horizontal decimation. Window configuration is sampled once per frame.
//
// Ports
//   clk, reset        pixel clock, synchronous active-high reset
//   cap_en            capture enable (level)
//   cfg_x0, cfg_y0    first captured tv_x / tv_y (1-based)
//   cfg_w, cfg_h      output pixels per line, lines per field
//   cfg_mode          0 field0, 1 field1, 2 weave, 3 same as 0
//   cfg_hdec          keep every second pixel of the input span
//   tv_field, tv_x, tv_y, tv_dval, data_in   decoder pixel stream
//   data_out, addr_lin, dval                  captured pixel, 1 clk latency
//   sof, eof          first / last pixel of a frame
//   short_err         field ended before the window completed
//   busy              not idle
//   frame_cnt         completed frames, wrapping
//
// state | meaning
// IDLE  | capture disabled
// ARM   | waiting for the start field's first pixel, config latched there
// CAP   | capturing the current field through the window
// WAIT1 | weave: field 0 done, waiting for field 1
module tv_window_capture #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 21,
  parameter int XY_W   = 10,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [XY_W-1:0]   cfg_x0,
  input  logic [XY_W-1:0]   cfg_y0,
  input  logic [XY_W-1:0]   cfg_w,
  input  logic [XY_W-1:0]   cfg_h,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_hdec,
  input  logic              tv_field,
  input  logic [XY_W-1:0]   tv_x,
  input  logic [XY_W-1:0]   tv_y,
  input  logic              tv_dval,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_lin,
  output logic              dval,
  output logic              sof,
  output logic              eof,
  output logic              short_err,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  // two spare bits so window ends (x0 + 2*w) never overflow
  localparam int XW = XY_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_WAIT1} state_t;

  state_t state, state_dec, state_nxt;

  logic [XY_W-1:0]   x0_r, y0_r, w_r, h_r;
  logic [1:0]        mode_r;
  logic              hdec_r, field_r, started_r;
  logic [ADDR_W-1:0] line_base_r;
  logic [XY_W-1:0]   px_cnt_r;

  logic       latch, enter, active, field_new, short_n;
  logic [1:0] live_mode;
  logic       live_start_f, fs, start_live, short_hit;

  assign live_mode    = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
  assign live_start_f = (live_mode == 2'd1);
  assign fs           = tv_dval && (tv_x == XY_W'(1)) && (tv_y == XY_W'(1));
  assign start_live   = cap_en && fs && (tv_field == live_start_f);
  // a line number falling below y0 only means a new field once the window has begun
  assign short_hit    = fs || (started_r && tv_dval && (tv_y < y0_r));

  always_comb begin
    state_dec = state;
    latch     = 1'b0;
    enter     = 1'b0;
    active    = 1'b0;
    field_new = field_r;
    short_n   = 1'b0;
    case (state)
      S_IDLE: if (cap_en) state_dec = S_ARM;
      S_ARM: begin
        if (!cap_en) state_dec = S_IDLE;
        else if (start_live) begin
          latch     = 1'b1;
          enter     = 1'b1;
          field_new = live_start_f;
          state_dec = S_CAP;
        end
      end
      S_CAP: begin
        if (short_hit) begin
          short_n = 1'b1;
          // the interrupting field start may itself begin a new frame
          if (start_live) begin
            latch     = 1'b1;
            enter     = 1'b1;
            field_new = live_start_f;
            state_dec = S_CAP;
          end else begin
            state_dec = cap_en ? S_ARM : S_IDLE;
          end
        end else begin
          active = 1'b1;
        end
      end
      S_WAIT1: begin
        if (!cap_en) state_dec = S_IDLE;
        else if (fs) begin
          // field 0 here restarts the weave frame with the same config
          enter     = 1'b1;
          field_new = tv_field;
          state_dec = S_CAP;
        end
      end
      default: state_dec = S_IDLE;
    endcase
  end

  // Window config in force this cycle: live ports on the latch cycle, else the latched copy.
  logic [XY_W-1:0] e_x0, e_y0, e_w, e_h;
  logic [1:0]      e_mode;
  logic            e_hdec, e_field;

  assign e_x0    = latch ? cfg_x0    : x0_r;
  assign e_y0    = latch ? cfg_y0    : y0_r;
  assign e_w     = latch ? cfg_w     : w_r;
  assign e_h     = latch ? cfg_h     : h_r;
  assign e_mode  = latch ? live_mode : mode_r;
  assign e_hdec  = latch ? cfg_hdec  : hdec_r;
  assign e_field = field_new;

  logic [XW-1:0] xs, ys, x0e, y0e, span, last_x, last_y;
  logic          in_x, in_y, dec_ok, q, line_first, first_line, last, weave, frame_end, first_px;

  assign xs     = XW'(tv_x);
  assign ys     = XW'(tv_y);
  assign x0e    = XW'(e_x0);
  assign y0e    = XW'(e_y0);
  assign span   = XW'(e_w) << e_hdec;
  assign last_x = x0e + (XW'(e_w - XY_W'(1)) << e_hdec);
  assign last_y = y0e + XW'(e_h) - XW'(1);

  assign in_x       = (xs >= x0e) && (xs < x0e + span);
  assign in_y       = (ys >= y0e) && (ys < y0e + XW'(e_h));
  assign dec_ok     = !e_hdec || (tv_x[0] == e_x0[0]);
  assign q          = (active || enter) && tv_dval && (tv_field == e_field) && in_x && in_y && dec_ok;
  assign line_first = (tv_x == e_x0);
  assign first_line = (tv_y == e_y0);
  assign last       = q && (xs == last_x) && (ys == last_y);
  assign weave      = (e_mode == 2'd2);
  assign frame_end  = last && !(weave && !e_field);
  assign first_px   = q && line_first && first_line && (e_field == (e_mode == 2'd1));

  assign state_nxt = !last ? state_dec :
                     (weave && !e_field) ? S_WAIT1 :
                     (cap_en ? S_ARM : S_IDLE);

  // line_base steps by one stride per line (two lines' worth in weave) instead of multiplying.
  logic [ADDR_W-1:0] stride, addr_calc;

  assign stride = weave ? (ADDR_W'(e_w) << 1) : ADDR_W'(e_w);

  always_comb begin
    addr_calc = line_base_r + ADDR_W'(px_cnt_r);
    if (line_first) begin
      if (first_line) addr_calc = (weave && e_field) ? ADDR_W'(e_w) : '0;
      else            addr_calc = line_base_r + stride;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      x0_r        <= '0;
      y0_r        <= '0;
      w_r         <= '0;
      h_r         <= '0;
      mode_r      <= '0;
      hdec_r      <= 1'b0;
      field_r     <= 1'b0;
      started_r   <= 1'b0;
      line_base_r <= '0;
      px_cnt_r    <= '0;
      data_out    <= '0;
      addr_lin    <= '0;
      dval        <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      short_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        x0_r   <= cfg_x0;
        y0_r   <= cfg_y0;
        w_r    <= cfg_w;
        h_r    <= cfg_h;
        mode_r <= live_mode;
        hdec_r <= cfg_hdec;
      end
      if (enter) begin
        field_r   <= field_new;
        started_r <= q;
      end else if (q) begin
        started_r <= 1'b1;
      end
      if (q) begin
        if (line_first) line_base_r <= addr_calc;
        px_cnt_r <= line_first ? XY_W'(1) : px_cnt_r + XY_W'(1);
        data_out <= data_in;
        addr_lin <= addr_calc;
      end
      dval      <= q;
      sof       <= first_px;
      eof       <= frame_end;
      short_err <= short_n;
      if (frame_end) frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_tv_window_capture.sv
// Bench for tv_window_capture: drives a small synthetic interlaced source
// (24 pixels x 10 lines per field) and predicts every captured pixel from the
// window arithmetic, checking each dval against the prediction.
module tb_tv_window_capture;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 21;
  localparam int XY_W     = 10;
  localparam int FCNT_W   = 8;
  localparam int LINE_LEN = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, cap_en, cfg_hdec, tv_field, tv_dval;
  logic [XY_W-1:0]   cfg_x0, cfg_y0, cfg_w, cfg_h, tv_x, tv_y;
  logic [1:0]        cfg_mode;
  logic [DATA_W-1:0] data_in, data_out;
  logic [ADDR_W-1:0] addr_lin;
  logic              dval, sof, eof, short_err, busy;
  logic [FCNT_W-1:0] frame_cnt;

  tv_window_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .XY_W(XY_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .reset(reset), .cap_en(cap_en),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_mode(cfg_mode), .cfg_hdec(cfg_hdec),
    .tv_field(tv_field), .tv_x(tv_x), .tv_y(tv_y), .tv_dval(tv_dval), .data_in(data_in),
    .data_out(data_out), .addr_lin(addr_lin), .dval(dval), .sof(sof), .eof(eof),
    .short_err(short_err), .busy(busy), .frame_cnt(frame_cnt)
  );

  typedef struct { int x0; int y0; int w; int h; int mode; int hdec; } cfg_t;
  typedef struct { int data; int addr; bit sof; bit eof; int fc; int cyc; } exp_t;

  exp_t expq[$];
  int cyc = 0;
  int n_checks = 0, n_pass = 0;
  int n_dval = 0, n_short = 0, n_eof = 0, n_sofeof = 0;
  int max_addr = 0, last_addr = 0, last_data = 0, model_fc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endfunction

  // Expected output for one source pixel of a field being captured with config c.
  function automatic void model_pixel(input int f, input int x, input int y, input cfg_t c);
    int m, span, k, row;
    exp_t e;
    m    = (c.mode == 3) ? 0 : c.mode;
    span = c.w << c.hdec;
    if (x < c.x0 || x >= c.x0 + span || y < c.y0 || y >= c.y0 + c.h) return;
    if (c.hdec != 0 && ((x - c.x0) % 2) != 0) return;
    k      = (x - c.x0) >> c.hdec;
    row    = (m == 2) ? 2 * (y - c.y0) + f : y - c.y0;
    e.addr = (row * c.w + k) % (1 << ADDR_W);
    e.data = (f << 15) | (y << 8) | x;
    e.sof  = (k == 0 && y == c.y0 && f == ((m == 1) ? 1 : 0));
    e.eof  = (k == c.w - 1 && y == c.y0 + c.h - 1 && (m != 2 || f == 1));
    if (e.eof) model_fc = (model_fc + 1) % (1 << FCNT_W);
    e.fc   = model_fc;
    e.cyc  = cyc;
    expq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (short_err === 1'b1) n_short++;
    if (dval === 1'b1) begin
      n_dval++;
      if (eof) n_eof++;
      if (sof && eof) n_sofeof++;
      if (int'(addr_lin) > max_addr) max_addr = int'(addr_lin);
      last_addr = int'(addr_lin);
      last_data = int'(data_out);
      if (expq.size() == 0) begin
        check(1'b0, "spurious_dval", $sformatf("got dval addr=%0d data=%h, required no dval", addr_lin, data_out));
      end else begin
        e = expq.pop_front();
        check(data_out == DATA_W'(e.data) && addr_lin == ADDR_W'(e.addr) && sof == e.sof &&
              eof == e.eof && frame_cnt == FCNT_W'(e.fc) && cyc == e.cyc + 1, "pixel",
              $sformatf("got data=%h addr=%0d sof=%0b eof=%0b fc=%0d cyc=%0d, required data=%h addr=%0d sof=%0b eof=%0b fc=%0d cyc=%0d",
                        data_out, addr_lin, sof, eof, frame_cnt, cyc,
                        e.data[DATA_W-1:0], e.addr, e.sof, e.eof, e.fc, e.cyc + 1));
      end
    end
  end

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      tv_dval = 1'b0;
    end
  endtask

  task automatic set_cfg(input cfg_t c);
    cfg_x0   = XY_W'(c.x0);
    cfg_y0   = XY_W'(c.y0);
    cfg_w    = XY_W'(c.w);
    cfg_h    = XY_W'(c.h);
    cfg_mode = 2'(c.mode);
    cfg_hdec = 1'(c.hdec);
  endtask

  // Drives one field of nl lines. cap says whether the DUT should be capturing it.
  // chg_line: change cfg_w to chg_w at the start of that line. rst_line: pulse reset after that line.
  task automatic drive_field(input int f, input int nl, input bit cap, input cfg_t c,
                             input int chg_line, input int chg_w, input int rst_line);
    for (int y = 1; y <= nl; y++) begin
      if (y == chg_line) cfg_w = XY_W'(chg_w);
      for (int x = 1; x <= LINE_LEN; x++) begin
        @(negedge clk);
        tv_dval  = 1'b1;
        tv_field = 1'(f);
        tv_x     = XY_W'(x);
        tv_y     = XY_W'(y);
        data_in  = DATA_W'((f << 15) | (y << 8) | x);
        if (cap) model_pixel(f, x, y, c);
      end
      idle_cyc(1);
      if (y == rst_line) begin
        @(negedge clk);
        tv_dval = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        cap      = 1'b0;
        model_fc = 0;
        check(dval == 0 && sof == 0 && eof == 0 && short_err == 0 && busy == 0 &&
              frame_cnt == 0 && data_out == 0 && addr_lin == 0, "midframe_reset",
              $sformatf("got dval=%0b sof=%0b eof=%0b err=%0b busy=%0b fc=%0d data=%h addr=%0d, required all 0",
                        dval, sof, eof, short_err, busy, frame_cnt, data_out, addr_lin));
      end else begin
        idle_cyc(1);
      end
    end
    idle_cyc(3);
  endtask

  task automatic expect_int(input string name, input int got, input int req);
    check(got == req, name, $sformatf("got %0d, required %0d", got, req));
  endtask

  initial begin
    cfg_t c, c2;
    int b_dval, b_short, b_eof, b_se;
    reset = 1'b1; cap_en = 1'b0; tv_dval = 1'b0; tv_field = 1'b0;
    tv_x = '0; tv_y = '0; data_in = '0;
    c = '{1, 1, 24, 10, 0, 0};
    set_cfg(c);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check(dval == 0 && sof == 0 && eof == 0 && short_err == 0 && busy == 0 &&
          frame_cnt == 0 && data_out == 0 && addr_lin == 0, "reset_state",
          $sformatf("got dval=%0b sof=%0b eof=%0b err=%0b busy=%0b fc=%0d data=%h addr=%0d, required all 0",
                    dval, sof, eof, short_err, busy, frame_cnt, data_out, addr_lin));

    // full-field capture, field 1 ignored
    cap_en = 1'b1;
    idle_cyc(2);
    expect_int("arm_busy", int'(busy), 1);
    b_dval = n_dval;
    drive_field(0, 10, 1'b1, c, 0, 0, 0);
    drive_field(1, 10, 1'b0, c, 0, 0, 0);
    cap_en = 1'b0;
    idle_cyc(3);
    expect_int("full_count", n_dval - b_dval, 240);
    expect_int("full_fcnt", int'(frame_cnt), 1);
    expect_int("idle_busy", int'(busy), 0);

    // weave
    c = '{1, 1, 24, 10, 2, 0};
    set_cfg(c);
    cap_en = 1'b1;
    idle_cyc(2);
    b_dval = n_dval; max_addr = 0;
    drive_field(0, 10, 1'b1, c, 0, 0, 0);
    drive_field(1, 10, 1'b1, c, 0, 0, 0);
    cap_en = 1'b0;
    idle_cyc(3);
    expect_int("weave_count", n_dval - b_dval, 480);
    expect_int("weave_max_addr", max_addr, 479);
    expect_int("weave_fcnt", int'(frame_cnt), 2);

    // offset window, decimation, reserved mode behaves as field 0
    c = '{3, 2, 8, 5, 3, 1};
    set_cfg(c);
    cap_en = 1'b1;
    idle_cyc(2);
    b_dval = n_dval;
    drive_field(0, 10, 1'b1, c, 0, 0, 0);
    cap_en = 1'b0;
    idle_cyc(3);
    expect_int("hdec_count", n_dval - b_dval, 40);
    expect_int("hdec_last_addr", last_addr, 39);
    expect_int("hdec_last_data", last_data, 1553);
    expect_int("hdec_fcnt", int'(frame_cnt), 3);

    // short field: cut after 4 lines, new field 0 restarts immediately
    c = '{1, 1, 24, 10, 0, 0};
    set_cfg(c);
    cap_en = 1'b1;
    idle_cyc(2);
    b_dval = n_dval; b_short = n_short;
    drive_field(0, 4, 1'b1, c, 0, 0, 0);
    drive_field(0, 10, 1'b1, c, 0, 0, 0);
    cap_en = 1'b0;
    idle_cyc(3);
    expect_int("short_pulses", n_short - b_short, 1);
    expect_int("short_count", n_dval - b_dval, 336);
    expect_int("short_fcnt", int'(frame_cnt), 4);

    // config change mid-field applies to the next frame only
    c = '{1, 1, 12, 10, 0, 0};
    set_cfg(c);
    cap_en = 1'b1;
    idle_cyc(2);
    b_dval = n_dval;
    drive_field(0, 10, 1'b1, c, 5, 24, 0);
    drive_field(1, 10, 1'b0, c, 0, 0, 0);
    c2 = '{1, 1, 24, 10, 0, 0};
    drive_field(0, 10, 1'b1, c2, 0, 0, 0);
    cap_en = 1'b0;
    idle_cyc(3);
    expect_int("cfgchg_count", n_dval - b_dval, 360);
    expect_int("cfgchg_last_addr", last_addr, 239);
    expect_int("cfgchg_fcnt", int'(frame_cnt), 6);

    // 1x1 window on field 1: sof and eof together
    c = '{5, 3, 1, 1, 1, 0};
    set_cfg(c);
    cap_en = 1'b1;
    idle_cyc(2);
    b_dval = n_dval; b_se = n_sofeof;
    drive_field(0, 10, 1'b0, c, 0, 0, 0);
    drive_field(1, 10, 1'b1, c, 0, 0, 0);
    cap_en = 1'b0;
    idle_cyc(3);
    expect_int("one_px_count", n_dval - b_dval, 1);
    expect_int("one_px_sofeof", n_sofeof - b_se, 1);
    expect_int("one_px_data", last_data, 33541);
    expect_int("one_px_fcnt", int'(frame_cnt), 7);

    // reset during capture, then cap_en dropped while waiting for field 1
    c = '{1, 1, 24, 10, 0, 0};
    set_cfg(c);
    cap_en = 1'b1;
    idle_cyc(2);
    b_dval = n_dval; b_short = n_short; b_eof = n_eof;
    drive_field(0, 10, 1'b1, c, 0, 0, 2);
    expect_int("reset_cut_count", n_dval - b_dval, 48);
    c = '{1, 1, 24, 10, 2, 0};
    set_cfg(c);
    b_dval = n_dval;
    drive_field(0, 10, 1'b1, c, 0, 0, 0);
    cap_en = 1'b0;
    idle_cyc(2);
    expect_int("wait1_drop_busy", int'(busy), 0);
    drive_field(1, 10, 1'b0, c, 0, 0, 0);
    expect_int("wait1_drop_count", n_dval - b_dval, 240);
    expect_int("abort_no_eof", n_eof - b_eof, 0);
    expect_int("abort_no_short", n_short - b_short, 0);
    expect_int("abort_fcnt", int'(frame_cnt), 0);

    idle_cyc(4);
    expect_int("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
